// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, constants and the IF/ID entry type
package pipeline_pkg;

    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam int              IMEM_BYTES = 1024;
    localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
    } if_id_t;

    // A bubble carries no PC information so downstream never mistakes it for a real slot
    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.valid    = 1'b0;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.instr    = nop;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold, flush-to-bubble and async reset
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Flush wins over hold so a redirect squashes the slot even while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= if_id_bubble(BUBBLE_INSTR);
        end else if (flush) begin
            q <= if_id_bubble(BUBBLE_INSTR);
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: program counter, imem address, IF/ID capture, stall/redirect
module fetch_stage
    import pipeline_pkg::if_id_t;
#(
    parameter int              XLEN       = pipeline_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = pipeline_pkg::RESET_PC,
    parameter int              IMEM_BYTES = pipeline_pkg::IMEM_BYTES,
    parameter logic [31:0]     NOP_INSTR  = pipeline_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [31:0]     if_id_instr,
    output logic            fetch_fault,
    output logic            redirect_misaligned,
    output logic [31:0]     fetch_count
);

    // Compared one bit wider so the last legal word address cannot overflow
    localparam logic [XLEN:0] LAST_FETCH = (XLEN+1)'(IMEM_BYTES - 4);

    logic            [XLEN-1:0] pc;
    logic            [XLEN-1:0] pc_plus4;
    logic                       out_of_range;
    logic                       advance;
    logic                       squash;
    if_id_t                     fetched;
    if_id_t                     if_id_q;

    assign imem_addr    = pc;
    assign pc_plus4     = pc + XLEN'(4);
    assign out_of_range = {1'b0, pc} > LAST_FETCH;
    assign advance      = !redirect_valid && !stall;
    assign squash       = redirect_valid || (advance && out_of_range);

    always_comb begin
        fetched          = '0;
        fetched.valid    = 1'b1;
        fetched.pc       = pc;
        fetched.pc_plus4 = pc_plus4;
        fetched.instr    = imem_instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_target[XLEN-1:1], 1'b0};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count         <= '0;
            fetch_fault         <= 1'b0;
            redirect_misaligned <= 1'b0;
        end else begin
            if (advance && !out_of_range) begin
                fetch_count <= fetch_count + 32'd1;
            end
            fetch_fault         <= advance && out_of_range;
            redirect_misaligned <= redirect_valid && redirect_target[0];
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall),
        .flush (squash),
        .d     (fetched),
        .q     (if_id_q)
    );

    assign if_id_valid    = if_id_q.valid;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural reference model
module tb_fetch_stage;

    localparam int          MEMB = 1024;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic        redirect_misaligned;
    logic [31:0] fetch_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [MEMB];

    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_count;
    logic        m_valid, m_fault, m_mis;

    fetch_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_addr           (imem_addr),
        .imem_instr          (imem_instr),
        .stall               (stall),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .if_id_valid         (if_id_valid),
        .if_id_pc            (if_id_pc),
        .if_id_pc_plus4      (if_id_pc_plus4),
        .if_id_instr         (if_id_instr),
        .fetch_fault         (fetch_fault),
        .redirect_misaligned (redirect_misaligned),
        .fetch_count         (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a > 32'(MEMB - 4)) return 32'hBAD0_BAD0;
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    always_comb imem_instr = rd_word(imem_addr);

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
        m_instr = NOP; m_count = 32'h0; m_fault = 1'b0; m_mis = 1'b0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".imem_addr"}, imem_addr, m_pc);
        chk({where, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        chk({where, ".pc"}, if_id_pc, m_ipc);
        chk({where, ".pc4"}, if_id_pc_plus4, m_ipc4);
        chk({where, ".instr"}, if_id_instr, m_instr);
        chk({where, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
        chk({where, ".misal"}, {31'b0, redirect_misaligned}, {31'b0, m_mis});
        chk({where, ".count"}, fetch_count, m_count);
    endtask

    // Reference: what one clock edge does under the stage's rules, evaluated before the edge
    task automatic step(input logic r, input logic [31:0] t, input logic s, input string where);
        redirect_valid  = r;
        redirect_target = t;
        stall           = s;
        m_fault = 1'b0;
        m_mis   = 1'b0;
        if (r) begin
            m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
            m_mis   = t[0];
            m_pc    = t & 32'hFFFF_FFFE;
        end else if (!s) begin
            if (longint'(m_pc) > longint'(MEMB - 4)) begin
                m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
                m_fault = 1'b1;
            end else begin
                m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                m_instr = rd_word(m_pc);
                m_count = m_count + 32'd1;
            end
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        logic [31:0] tgt;
        logic        r, s;

        for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
        put_word(32'h00, 32'h0062_8433);
        put_word(32'h04, 32'h0084_2483);
        put_word(32'h08, 32'h0054_EE33);
        put_word(32'h10, 32'h0062_9233);
        put_word(32'h36, 32'h4044_0333);

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        step(1'b0, 32'h0, 1'b0, "first");
        chk("tp_first_instr", if_id_instr, 32'h0062_8433);
        chk("tp_first_pc4", if_id_pc_plus4, 32'h4);
        step(1'b0, 32'h0, 1'b0, "second");
        chk("tp_second_instr", if_id_instr, 32'h0084_2483);
        chk("tp_count2", fetch_count, 32'd2);

        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, "stall");
        chk("tp_stall_addr", imem_addr, 32'h8);
        chk("tp_stall_instr", if_id_instr, 32'h0084_2483);
        step(1'b0, 32'h0, 1'b0, "unstall");
        chk("tp_unstall_instr", if_id_instr, 32'h0054_EE33);

        step(1'b1, 32'h36, 1'b1, "redir_stall");
        chk("tp_redir_addr", imem_addr, 32'h36);
        chk("tp_redir_instr", if_id_instr, NOP);
        step(1'b0, 32'h0, 1'b0, "after_redir");
        chk("tp_redir_fetch", if_id_instr, 32'h4044_0333);

        step(1'b1, 32'h11, 1'b0, "misal");
        chk("tp_misal_pulse", {31'b0, redirect_misaligned}, 32'h1);
        step(1'b0, 32'h0, 1'b0, "after_misal");
        chk("tp_misal_fetch", if_id_instr, 32'h0062_9233);

        step(1'b1, 32'h3FC, 1'b0, "to_3fc");
        step(1'b0, 32'h0, 1'b0, "fetch_3fc");
        step(1'b0, 32'h0, 1'b0, "fault_400");
        chk("tp_fault_pulse", {31'b0, fetch_fault}, 32'h1);
        step(1'b0, 32'h0, 1'b1, "fault_clear");
        chk("tp_fault_clear", {31'b0, fetch_fault}, 32'h0);

        step(1'b1, 32'hFFFF_FFFD, 1'b0, "to_top");
        step(1'b0, 32'h0, 1'b0, "top_fault");
        step(1'b0, 32'h0, 1'b0, "wrap_zero");
        chk("tp_wrap_addr", imem_addr, 32'h4);

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       tgt = 32'h3F0 + 32'($urandom_range(0, 31));
                default: tgt = 32'($urandom_range(0, MEMB - 1));
            endcase
            step(r, tgt, s, "rand");
        end

        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, "post_rst");
        chk("tp_post_rst_instr", if_id_instr, 32'h0062_8433);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, ($urandom_range(0, 2) == 0), "tail");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
